// File: rtl/adder_rr_arbiter_pkg.sv
// adder_arb_pkg: shared FSM state type and default sizing for adder_rr_arbiter
package adder_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        HOLD
    } state_t;

    localparam int OPCNT_W   = 16;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_NREQ  = 4;

endpackage

// File: rtl/adder_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set bit of req at or above ptr (mod NREQ)
//   req    : request vector
//   ptr    : search start index
//   found  : any request set
//   winner : index of the chosen request (0 when none)
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            found,
    output logic [IDW-1:0]  winner
);

    logic [IDW-1:0] idx;

    // Walk offsets from the farthest down to zero so the nearest hit wins.
    always_comb begin
        found  = |req;
        winner = '0;
        idx    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (req[idx]) winner = idx;
        end
    end

endmodule

// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter: round-robin sequencer sharing one external combinational adder among NREQ requesters
//   req_valid/req_ready/req_a/req_b/req_cin : per-requester operand handshake (packed i*WIDTH)
//   add_a/add_b/add_cin -> add_sum/add_cout : external adder, one cycle of budget
//   rsp_valid/rsp_ready/rsp_id/rsp_sum/rsp_cout : tagged result handshake
//   busy : operation in flight; op_count : completed responses (wrapping)
module adder_rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter  int NREQ  = DEF_NREQ,
    parameter  int WIDTH = DEF_WIDTH,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    output logic                  add_cin,
    input  logic [WIDTH-1:0]      add_sum,
    input  logic                  add_cout,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic                  busy,
    output logic [OPCNT_W-1:0]    op_count
);

    state_t               state_q, state_d;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;
    logic                 op_cin_q, op_cin_d;
    logic [IDW-1:0]       id_q, id_d, rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]     rsp_sum_q, rsp_sum_d;
    logic                 rsp_cout_q, rsp_cout_d;
    logic [OPCNT_W-1:0]   op_count_q, op_count_d;
    logic                 found;
    logic [IDW-1:0]       winner;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .found  (found),
        .winner (winner)
    );

    // Ready is granted to the winner whenever IDLE, so a found winner is always a handshake.
    assign req_ready = (rst_n && state_q == IDLE && found) ? NREQ'(1) << winner : '0;
    assign add_a     = op_a_q;
    assign add_b     = op_b_q;
    assign add_cin   = op_cin_q;
    assign rsp_valid = state_q == HOLD;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign busy      = rst_n && state_q != IDLE;
    assign op_count  = op_count_q;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_cin_d   = op_cin_q;
        id_d       = id_q;
        rsp_id_d   = rsp_id_q;
        rsp_sum_d  = rsp_sum_q;
        rsp_cout_d = rsp_cout_q;
        op_count_d = op_count_q;
        case (state_q)
            IDLE: if (found) begin
                op_a_d   = req_a[winner*WIDTH +: WIDTH];
                op_b_d   = req_b[winner*WIDTH +: WIDTH];
                op_cin_d = req_cin[winner];
                id_d     = winner;
                rr_ptr_d = (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
                state_d  = EXEC;
            end
            EXEC: begin
                rsp_sum_d  = add_sum;
                rsp_cout_d = add_cout;
                rsp_id_d   = id_q;
                state_d    = HOLD;
            end
            HOLD: if (rsp_ready) begin
                op_count_d = op_count_q + 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_cin_q   <= 1'b0;
            id_q       <= '0;
            rsp_id_q   <= '0;
            rsp_sum_q  <= '0;
            rsp_cout_q <= 1'b0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_cin_q   <= op_cin_d;
            id_q       <= id_d;
            rsp_id_q   <= rsp_id_d;
            rsp_sum_q  <= rsp_sum_d;
            rsp_cout_q <= rsp_cout_d;
            op_count_q <= op_count_d;
        end
    end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// tb_adder_rr_arbiter: directed + randomized self-checking bench against a round-robin/arithmetic reference model
module tb_adder_rr_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_ready, req_cin;
    logic [N*W-1:0] req_a, req_b;
    logic [W-1:0]   add_a, add_b, add_sum;
    logic           add_cin, add_cout;
    logic           rsp_valid, rsp_ready, rsp_cout, busy;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_sum;
    logic [15:0]    op_count;

    logic [W-1:0]   da [N];
    logic [W-1:0]   db [N];
    logic           dc [N];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int m_ptr = 0;
    int m_cnt = 0;
    int last_w, last_acc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_a[g*W +: W] = da[g];
        assign req_b[g*W +: W] = db[g];
        assign req_cin[g]      = dc[g];
    end

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + 33'(add_cin);

    adder_rr_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .busy      (busy),
        .op_count  (op_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rnd(input int i);
        da[i] = $urandom;
        db[i] = $urandom;
        dc[i] = 1'($urandom_range(0, 1));
    endtask

    // Runs one request/response transaction from an IDLE negedge; keep re-arms the winner with new data.
    task automatic run_op(input logic [N-1:0] mask, input bit keep, input int hold);
        int n, w;
        logic [32:0] exp;
        logic [W-1:0] ea;
        req_valid = mask;
        rsp_ready = 1'b0;
        #1;
        n = 0;
        while (req_ready == '0 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        if (n == 20) begin
            chk("grant_timeout", 64'(n), 64'(0));
            return;
        end
        w = -1;
        for (int k = N - 1; k >= 0; k--) if (mask[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        chk("grant", 64'(req_ready), 64'(1) << w);
        exp = {1'b0, da[w]} + {1'b0, db[w]} + 33'(dc[w]);
        ea = da[w];
        m_ptr = (w + 1) % N;
        last_w = w;
        last_acc = cyc;
        @(negedge clk); #1;
        if (keep) rnd(w);
        else req_valid[w] = 1'b0;
        chk("exec_state", {busy, rsp_valid, req_ready}, {1'b1, 1'b0, 4'b0});
        chk("exec_add_a", 64'(add_a), 64'(ea));
        rsp_ready = hold == 0;
        @(negedge clk); #1;
        chk("hold_valid", {rsp_valid, busy}, 2'b11);
        chk("rsp_id", 64'(rsp_id), 64'(w));
        chk("rsp_sum", 64'(rsp_sum), 64'(exp[31:0]));
        chk("rsp_cout", 64'(rsp_cout), 64'(exp[32]));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); #1;
            chk("hold_stable", {rsp_valid, rsp_id, rsp_sum, rsp_cout, req_ready, op_count},
                {1'b1, 2'(w), exp[31:0], exp[32], 4'b0, 16'(m_cnt)});
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        m_cnt++;
        chk("op_count", 64'(op_count), 64'(m_cnt));
        chk("idle_valid", {rsp_valid, busy}, 2'b00);
        rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        m_ptr = 0;
        m_cnt = 0;
    endtask

    initial begin
        int prev, ok;
        rst_n = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) rnd(i);
        do_reset();
        chk("rst_outputs", {req_ready, busy, rsp_valid, op_count, rsp_sum, add_a},
            {4'b0, 1'b0, 1'b0, 16'b0, 32'b0, 32'b0});
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // single request, fixed operands
        da[2] = 32'h5; db[2] = 32'h3; dc[2] = 1'b1;
        run_op(4'b0100, 0, 0);
        chk("single_sum", {rsp_id, rsp_sum}, {2'd2, 32'h9});
        // overflow cases
        da[0] = 32'hFFFF_FFFF; db[0] = 32'h1; dc[0] = 1'b0;
        run_op(4'b0001, 0, 0);
        da[1] = 32'hFFFF_FFFF; db[1] = 32'hFFFF_FFFF; dc[1] = 1'b1;
        run_op(4'b0010, 0, 0);
        // all four continuously after reset
        do_reset();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) rnd(i);
        @(negedge clk); #1;
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            run_op(4'b1111, 1, 0);
            chk("rr_order", 64'(last_w), 64'(i % N));
            if (i > 0) chk("period", 64'(last_acc - prev), 64'(3));
            prev = last_acc;
        end
        // back-pressure with req 1 still pending afterwards
        rnd(1);
        run_op(4'b0010, 1, 10);
        req_valid = 4'b0010;
        #1;
        chk("post_hold_grant", 64'(req_ready), 64'b0010);
        run_op(4'b0010, 0, 0);
        // random masks and operands
        for (int i = 0; i < 12; i++) begin
            logic [N-1:0] m;
            for (int j = 0; j < N; j++) rnd(j);
            m = N'($urandom_range(1, 15));
            run_op(m, 0, $urandom_range(0, 2));
        end
        // reset during EXEC
        req_valid = '1;
        #1;
        @(negedge clk); #1;
        chk("pre_rst_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk("rst_mid", {rsp_valid, busy, op_count, req_ready}, {1'b0, 1'b0, 16'b0, 4'b0});
        m_ptr = 0;
        m_cnt = 0;
        req_valid = '0;
        rst_n = 1'b1;
        ok = 1;
        repeat (5) begin
            @(negedge clk); #1;
            if (rsp_valid !== 1'b0) ok = 0;
        end
        chk("no_rsp_after_rst", 64'(ok), 64'(1));
        run_op(4'b1111, 0, 0);
        chk("ptr_reset_winner", 64'(last_w), 64'(0));
        // fairness: ptr=1, only req 3 and req 0 valid
        run_op(4'b1001, 1, 0);
        chk("fair_first", 64'(last_w), 64'(3));
        run_op(4'b1001, 0, 0);
        chk("fair_second", 64'(last_w), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/adder_rr_arbiter.md
# adder_rr_arbiter

Round-robin arbiter and sequencer that shares one combinational 32-bit adder among up to NREQ requesters in the FIR datapath. Each requester presents A/B/Cin over a valid/ready handshake. The block registers the winning operands, drives them to the external adder for one evaluation cycle, and captures the sum and carry-out. It then returns them, tagged with the requester ID, over a valid/ready response port. The adder stays outside the block, so the top level can swap adder architectures without touching sequencing.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 32, operand/sum width
- IDW, $clog2(NREQ), requester ID width (derived; not overridden)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_a  in  NREQ*WIDTH  operand A; requester i at [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand B, same packing
- req_cin  in  NREQ  carry-in per requester
- add_a  out  WIDTH  to adder, operand A
- add_b  out  WIDTH  to adder, operand B
- add_cin  out  1  to adder, carry-in
- add_sum  in  WIDTH  from adder, sum (combinational)
- add_cout  in  1  from adder, carry-out
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  IDW  index of requester that owns the result
- rsp_sum  out  WIDTH  captured sum
- rsp_cout  out  1  captured carry-out
- busy  out  1  high in EXEC or HOLD
- op_count  out  16  completed responses, wraps at 0xFFFF→0

## Operation
- FSM states: IDLE, EXEC, HOLD.
- IDLE:
  - Winner = first i with req_valid[i], searching from rr_ptr upward modulo NREQ.
  - req_ready[winner]=1; all other bits 0. If no valid, all 0.
  - On handshake (valid & ready): capture req_a/b/cin of winner into op regs and winner into id reg; rr_ptr ← (winner+1) mod NREQ; go to EXEC.
- EXEC:
  - add_a/add_b/add_cin driven from op regs.
  - At the end of the cycle, capture add_sum/add_cout into rsp_sum/rsp_cout and move id to rsp_id; go to HOLD.
- HOLD:
  - rsp_valid=1; rsp_* stable.
  - When rsp_ready=1: op_count++ and go to IDLE. Otherwise stay.
- req_ready is 0 in EXEC and HOLD. Requests stay pending, and requesters must hold valid and data stable until ready.
- add_* hold the last op reg values outside EXEC. The downstream ignores them there.
- Arithmetic: the adder result is taken as-is. No saturation; overflow appears only in rsp_cout.
- Reset (rst_n=0 at an edge, any state): state→IDLE, rr_ptr→0, op regs→0, rsp_valid/rsp_id/rsp_sum/rsp_cout→0, op_count→0. While rst_n=0, req_ready is forced 0 and busy=0. An in-flight operation is discarded and no response is issued.

## Timing
- Request accepted at edge T → EXEC during cycle T..T+1 → rsp_valid=1 from edge T+1.
- Minimum op period is 3 cycles (IDLE, EXEC, HOLD with rsp_ready=1).
- The adder has one full clock cycle of combinational budget, from op regs to rsp regs.
- req_ready depends combinationally on req_valid and state. No other combinational input-to-output paths.
- A simultaneous rsp_ready and new req_valid in HOLD does not accept the new request. It is accepted in the following IDLE cycle.

## Structure
- Package adder_arb_pkg: state enum (IDLE/EXEC/HOLD), OPCNT_W=16, default WIDTH/NREQ constants.
- Sub-module rr_pick: combinational round-robin picker. Inputs NREQ-bit request vector and IDW-bit pointer; outputs found flag and IDW-bit winner.
- The top holds the FSM, op/rsp registers, rr_ptr and op_count.

## Test plan
- Single request: req 2 with a=0x0000_0005, b=0x0000_0003, cin=1 → rsp_id=2, sum=0x9, cout=0, rsp_valid at accept+1, op_count=1.
- All four valid continuously after reset with rsp_ready=1 → grant order 0,1,2,3,0. Each requester is served once per 4 ops, one accept every 3 cycles.
- Overflow: a=0xFFFF_FFFF, b=0x0000_0001, cin=0 → sum=0x0, cout=1. Also a=b=0xFFFF_FFFF, cin=1 → sum=0xFFFF_FFFF, cout=1.
- Back-pressure: hold rsp_ready=0 for 10 cycles while req 1 is valid → rsp_* stable, req_ready=0 throughout. Release → op_count increments once and req 1 is granted the next cycle.
- Reset mid-op: rst_n=0 during EXEC → next cycle rsp_valid=0, busy=0, op_count=0, rr_ptr=0, and no response appears afterwards.
- Pointer fairness: only req 3 and req 0 valid, rr_ptr=1 → req 3 granted first, then req 0.
